// File: rtl/spmem_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// spmem_lsu_ctrl
//
// Load/store front-end for the sparse memory. Byte/half/word requests are
// queued in a small request FIFO and then issued one at a time onto the
// sparse-memory port. Each request returns one response: extended load data,
// a store acknowledgement, or an error for a misaligned access or an illegal
// size.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  request handshake (ready = FIFO not full)
//   req_we_i                 1 = store, 0 = load
//   req_size_i               00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i           loads: zero-extend instead of sign-extend
//   req_addr_i, req_wdata_i  byte address, right-aligned store data
//   rsp_valid_o/rsp_ready_i  response handshake
//   rsp_rdata_o, rsp_err_o   load data (0 for stores/errors), error flag
//   mem_cs_no                read chip select, active low
//   mem_re_o                 read op: 0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU
//   mem_read_address_o       word-aligned read address
//   mem_read_data_i          raw word from memory
//   mem_we_o                 write op: 0 NONE, 1 SB, 2 SH, 3 SW
//   mem_write_address_o      byte write address
//   mem_write_data_o         write data masked to the access size
// -----------------------------------------------------------------------------
module spmem_lsu_ctrl #(
   parameter int ADDR_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_unsigned_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [31:0]       req_wdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [31:0]       rsp_rdata_o,
   output logic              rsp_err_o,
   output logic              mem_cs_no,
   output logic [2:0]        mem_re_o,
   output logic [ADDR_W-1:0] mem_read_address_o,
   input  logic [31:0]       mem_read_data_i,
   output logic [1:0]        mem_we_o,
   output logic [ADDR_W-1:0] mem_write_address_o,
   output logic [31:0]       mem_write_data_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic              we;
      logic [1:0]        size;
      logic              uns;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
   } req_t;

   // Only what load extraction needs survives past the pop.
   typedef struct packed {
      logic [1:0] size;
      logic       uns;
      logic [1:0] lane;
   } cur_t;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WRITE    = 3'd1,
      S_RD_ISSUE = 3'd2,
      S_RD_WAIT  = 3'd3,
      S_RESP     = 3'd4
   } state_t;

   // ---------------------------------------------------------------- helpers
   function automatic logic is_illegal(req_t r);
      return (r.size == 2'b11) ||
             (r.size == 2'b01 && r.addr[0]) ||
             (r.size == 2'b10 && r.addr[1:0] != 2'b00);
   endfunction

   function automatic logic [2:0] load_op(req_t r);
      case (r.size)
         2'b00:   return r.uns ? 3'd4 : 3'd1;
         2'b01:   return r.uns ? 3'd5 : 3'd2;
         default: return 3'd3;
      endcase
   endfunction

   function automatic logic [31:0] mask_wdata(logic [1:0] size, logic [31:0] w);
      case (size)
         2'b00:   return {24'h0, w[7:0]};
         2'b01:   return {16'h0, w[15:0]};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] extract(cur_t c, logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(w >> {c.lane, 3'b000});
      h = 16'(w >> {c.lane[1], 4'b0000});
      case (c.size)
         2'b00:   return c.uns ? {24'h0, b} : {{24{b[7]}}, b};
         2'b01:   return c.uns ? {16'h0, h} : {{16{h[15]}}, h};
         default: return w;
      endcase
   endfunction

   // ---------------------------------------------------------- request FIFO
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   req_t             fifo_q [FIFO_DEPTH];
   logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
   logic             full, empty, push, pop;
   req_t             in_req, head;
   state_t           state_q, state_d;
   cur_t             cur_q, cur_d;

   assign in_req = '{we: req_we_i, size: req_size_i, uns: req_unsigned_i,
                     addr: req_addr_i, wdata: req_wdata_i};

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                  (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign req_ready_o = !full;
   assign push  = req_valid_i && !full;
   // The FSM only looks at registered FIFO state, so a request always sits
   // in the FIFO for at least one cycle.
   assign pop   = (state_q == S_IDLE) && !empty;
   assign head  = fifo_q[rd_ptr_q[PTR_W-1:0]];

   always_ff @(posedge clk_i) begin
      if (push) fifo_q[wr_ptr_q[PTR_W-1:0]] <= in_req;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // --------------------------------------------------------- state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         cur_q   <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
      end
   end

   // ------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               cur_d = '{size: head.size, uns: head.uns, lane: head.addr[1:0]};
               if (is_illegal(head)) state_d = S_RESP;
               else if (head.we)     state_d = S_WRITE;
               else                  state_d = S_RD_ISSUE;
            end
         end
         S_WRITE:    state_d = S_RESP;
         S_RD_ISSUE: state_d = S_RD_WAIT;
         S_RD_WAIT:  state_d = S_RESP;
         S_RESP:     if (rsp_ready_i) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   // Every output is a flop; this block computes its value for the state
   // being entered, so the memory port is glitch-free.
   logic              cs_d, rsp_valid_d, rsp_err_d;
   logic [2:0]        re_d;
   logic [1:0]        we_d;
   logic [ADDR_W-1:0] raddr_d, waddr_d;
   logic [31:0]       wdata_d, rsp_rdata_d;

   always_comb begin
      cs_d        = 1'b1;
      re_d        = 3'd0;
      raddr_d     = '0;
      we_d        = 2'd0;
      waddr_d     = '0;
      wdata_d     = '0;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               if (is_illegal(head)) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else if (head.we) begin
                  we_d    = head.size + 2'd1;
                  waddr_d = head.addr;
                  wdata_d = mask_wdata(head.size, head.wdata);
               end else begin
                  cs_d    = 1'b0;
                  re_d    = load_op(head);
                  raddr_d = {head.addr[ADDR_W-1:2], 2'b00};
               end
            end
         end
         S_WRITE: rsp_valid_d = 1'b1;
         S_RD_ISSUE: begin
            // chip select drops after one cycle; op and address stay put
            re_d    = mem_re_o;
            raddr_d = mem_read_address_o;
         end
         S_RD_WAIT: begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = extract(cur_q, mem_read_data_i);
         end
         S_RESP: begin
            if (!rsp_ready_i) begin
               rsp_valid_d = rsp_valid_o;
               rsp_rdata_d = rsp_rdata_o;
               rsp_err_d   = rsp_err_o;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_cs_no           <= 1'b1;
         mem_re_o            <= 3'd0;
         mem_read_address_o  <= '0;
         mem_we_o            <= 2'd0;
         mem_write_address_o <= '0;
         mem_write_data_o    <= '0;
         rsp_valid_o         <= 1'b0;
         rsp_rdata_o         <= '0;
         rsp_err_o           <= 1'b0;
      end else begin
         mem_cs_no           <= cs_d;
         mem_re_o            <= re_d;
         mem_read_address_o  <= raddr_d;
         mem_we_o            <= we_d;
         mem_write_address_o <= waddr_d;
         mem_write_data_o    <= wdata_d;
         rsp_valid_o         <= rsp_valid_d;
         rsp_rdata_o         <= rsp_rdata_d;
         rsp_err_o           <= rsp_err_d;
      end
   end

endmodule

// File: tb/tb_spmem_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spmem_lsu_ctrl
//
// Bench for spmem_lsu_ctrl: a vector table of single requests with expected
// response and memory-port activity, a scoreboard of expected responses, a
// small sparse-memory model, and hand-written back-pressure and
// reset-during-read sequences.
// -----------------------------------------------------------------------------
module tb_spmem_lsu_ctrl;
   localparam int ADDR_W     = 32;
   localparam int FIFO_DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst_ni;
   logic              req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
   logic [1:0]        req_size_i;
   logic [ADDR_W-1:0] req_addr_i;
   logic [31:0]       req_wdata_i;
   logic              rsp_valid_o, rsp_ready_i, rsp_err_o;
   logic [31:0]       rsp_rdata_o;
   logic              mem_cs_no;
   logic [2:0]        mem_re_o;
   logic [ADDR_W-1:0] mem_read_address_o, mem_write_address_o;
   logic [31:0]       mem_read_data_i, mem_write_data_o;
   logic [1:0]        mem_we_o;

   always #5 clk = ~clk;

   spmem_lsu_ctrl #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_we_i(req_we_i), .req_size_i(req_size_i),
      .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
      .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .mem_cs_no(mem_cs_no), .mem_re_o(mem_re_o),
      .mem_read_address_o(mem_read_address_o),
      .mem_read_data_i(mem_read_data_i),
      .mem_we_o(mem_we_o), .mem_write_address_o(mem_write_address_o),
      .mem_write_data_o(mem_write_data_o)
   );

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;   // expected response data
      logic        err;     // expected error flag
      int          lat;     // edges from push to rsp_valid
      int          ncs;     // expected cycles with mem_cs_no low
      int          nwe;     // expected cycles with mem_we_o != NONE
      logic [2:0]  op;      // expected mem_re_o or mem_we_o
      logic [31:0] maddr;   // expected memory address
      logic [31:0] mdata;   // expected write data
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          at_cyc;
      bit          chk_lat;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   exp_t e_pop;
   exp_t e_new;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int cs_total = 0, we_total = 0, rsp_total = 0;
   logic [2:0]  cap_re;
   logic [31:0] cap_raddr, cap_waddr, cap_wdata;
   logic [1:0]  cap_we;

   logic [31:0] bp_addr [5] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h200};
   logic [1:0]  bp_size [5] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2};
   logic [31:0] bp_exp  [5] = '{32'hF0, 32'h60, 32'h70, 32'h80, 32'hDEADBEEF};

   // ------------------------------------------------------ sparse memory model
   logic [31:0] smem [logic [31:0]];
   logic [31:0] mem_rd_q = 32'h0;
   assign mem_read_data_i = mem_rd_q;

   function automatic logic [31:0] rd_word(logic [31:0] a);
      logic [31:0] k;
      k = {a[31:2], 2'b00};
      return smem.exists(k) ? smem[k] : 32'h0;
   endfunction

   task automatic wr_mem(logic [1:0] op, logic [31:0] a, logic [31:0] d);
      logic [31:0] w;
      w = rd_word(a);
      case (op)
         2'd1:    w[8*a[1:0] +: 8]  = d[7:0];
         2'd2:    w[16*a[1] +: 16]  = d[15:0];
         default: w = d;
      endcase
      smem[{a[31:2], 2'b00}] = w;
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!mem_cs_no) mem_rd_q <= rd_word(mem_read_address_o);
      if (mem_we_o != 2'd0) wr_mem(mem_we_o, mem_write_address_o, mem_write_data_o);
   end

   // ---------------------------------------------------------------- checking
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: memory-port activity counters and response scoreboard.
   always @(negedge clk) begin
      if (!mem_cs_no) begin
         cs_total++;
         cap_re    = mem_re_o;
         cap_raddr = mem_read_address_o;
      end
      if (mem_we_o != 2'd0) begin
         we_total++;
         cap_we    = mem_we_o;
         cap_waddr = mem_write_address_o;
         cap_wdata = mem_write_data_o;
      end
      if (rsp_valid_o && rsp_ready_i) begin
         rsp_total++;
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_rsp: got rdata %h err %0b expected none",
                     rsp_rdata_o, rsp_err_o);
         end else begin
            e_pop = sb.pop_front();
            chk("rsp_rdata", rsp_rdata_o, e_pop.rdata);
            chk("rsp_err", 32'(rsp_err_o), 32'(e_pop.err));
            if (e_pop.chk_lat) chk("rsp_latency", 32'(cyc), 32'(e_pop.at_cyc));
         end
      end
   end

   task automatic add(logic we, logic [1:0] sz, logic uns, logic [31:0] a,
                      logic [31:0] wd, logic [31:0] rd, logic er, int lat,
                      int ncs, int nwe, logic [2:0] op, logic [31:0] ma,
                      logic [31:0] md);
      vec_t v;
      v.we = we; v.size = sz; v.uns = uns; v.addr = a; v.wdata = wd;
      v.rdata = rd; v.err = er; v.lat = lat; v.ncs = ncs; v.nwe = nwe;
      v.op = op; v.maddr = ma; v.mdata = md;
      tbl.push_back(v);
   endtask

   task automatic run_vec(vec_t v, int idx);
      int cs0, we0, r0, k;
      cs0 = cs_total; we0 = we_total; r0 = rsp_total;
      req_we_i = v.we; req_size_i = v.size; req_unsigned_i = v.uns;
      req_addr_i = v.addr; req_wdata_i = v.wdata; req_valid_i = 1'b1;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      e_new.rdata = v.rdata; e_new.err = v.err;
      e_new.at_cyc = cyc + v.lat; e_new.chk_lat = 1'b1;
      sb.push_back(e_new);
      k = 0;
      while (rsp_total == r0 && k < 20) begin
         @(posedge clk);
         k++;
      end
      if (rsp_total == r0) begin
         n_vec++;
         n_err++;
         $display("FAIL v%0d_rsp_timeout: got no response expected one", idx);
         sb.delete();
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d_cs_cycles", idx), 32'(cs_total - cs0), 32'(v.ncs));
      chk($sformatf("v%0d_we_cycles", idx), 32'(we_total - we0), 32'(v.nwe));
      if (v.ncs != 0) begin
         chk($sformatf("v%0d_mem_re", idx), 32'(cap_re), 32'(v.op));
         chk($sformatf("v%0d_raddr", idx), cap_raddr, v.maddr);
      end
      if (v.nwe != 0) begin
         chk($sformatf("v%0d_mem_we", idx), 32'(cap_we), 32'(v.op));
         chk($sformatf("v%0d_waddr", idx), cap_waddr, v.maddr);
         chk($sformatf("v%0d_wdata", idx), cap_wdata, v.mdata);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, cs0, k;
      rst_ni = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'd0;
      req_unsigned_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
      rsp_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready_o), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata_o, 32'h0);
      chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
      chk("rst_cs_n", 32'(mem_cs_no), 32'd1);
      chk("rst_mem_re", 32'(mem_re_o), 32'd0);
      chk("rst_mem_we", 32'(mem_we_o), 32'd0);
      chk("rst_raddr", mem_read_address_o, 32'h0);
      chk("rst_waddr", mem_write_address_o, 32'h0);
      chk("rst_wdata", mem_write_data_o, 32'h0);
      @(negedge clk) rst_ni = 1'b1;
      @(posedge clk); #1;

      //   we   sz  uns addr      wdata         rdata         err lat cs we op ma        md
      add(1, 2'd2, 0, 32'h100, 32'h807060F0, 32'h0,        0, 2, 0, 1, 3, 32'h100, 32'h807060F0);
      add(0, 2'd0, 0, 32'h100, 32'h0,        32'hFFFFFFF0, 0, 3, 1, 0, 1, 32'h100, 32'h0);
      add(0, 2'd0, 1, 32'h103, 32'h0,        32'h00000080, 0, 3, 1, 0, 4, 32'h100, 32'h0);
      add(0, 2'd1, 0, 32'h102, 32'h0,        32'hFFFF8070, 0, 3, 1, 0, 2, 32'h100, 32'h0);
      add(0, 2'd1, 1, 32'h100, 32'h0,        32'h000060F0, 0, 3, 1, 0, 5, 32'h100, 32'h0);
      add(0, 2'd0, 0, 32'h101, 32'h0,        32'h00000060, 0, 3, 1, 0, 1, 32'h100, 32'h0);
      add(1, 2'd2, 0, 32'h200, 32'hDEADBEEF, 32'h0,        0, 2, 0, 1, 3, 32'h200, 32'hDEADBEEF);
      add(0, 2'd2, 0, 32'h200, 32'h0,        32'hDEADBEEF, 0, 3, 1, 0, 3, 32'h200, 32'h0);
      add(1, 2'd0, 0, 32'h204, 32'h123456AB, 32'h0,        0, 2, 0, 1, 1, 32'h204, 32'h000000AB);
      add(1, 2'd1, 0, 32'h206, 32'hFFFF1234, 32'h0,        0, 2, 0, 1, 2, 32'h206, 32'h00001234);
      add(0, 2'd2, 0, 32'h204, 32'h0,        32'h123400AB, 0, 3, 1, 0, 3, 32'h204, 32'h0);
      add(0, 2'd1, 1, 32'h206, 32'h0,        32'h00001234, 0, 3, 1, 0, 5, 32'h204, 32'h0);
      add(0, 2'd0, 0, 32'h207, 32'h0,        32'h00000012, 0, 3, 1, 0, 1, 32'h204, 32'h0);
      add(0, 2'd2, 0, 32'h102, 32'h0,        32'h0,        1, 1, 0, 0, 0, 32'h0,   32'h0);
      add(1, 2'd1, 0, 32'h301, 32'h5555,     32'h0,        1, 1, 0, 0, 0, 32'h0,   32'h0);
      add(0, 2'd3, 0, 32'h100, 32'h0,        32'h0,        1, 1, 0, 0, 0, 32'h0,   32'h0);
      add(0, 2'd1, 0, 32'h101, 32'h0,        32'h0,        1, 1, 0, 0, 0, 32'h0,   32'h0);
      add(1, 2'd2, 0, 32'h202, 32'h77777777, 32'h0,        1, 1, 0, 0, 0, 32'h0,   32'h0);
      add(0, 2'd2, 1, 32'h100, 32'h0,        32'h807060F0, 0, 3, 1, 0, 3, 32'h100, 32'h0);

      for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

      // Back-pressure: five loads are taken (one in RESP, four queued),
      // the sixth sees req_ready_o low.
      rsp_ready_i = 1'b0;
      r0 = rsp_total;
      for (int i = 0; i < 6; i++) begin
         req_we_i = 1'b0;
         req_unsigned_i = 1'b1;
         req_size_i = (i < 5) ? bp_size[i] : 2'd0;
         req_addr_i = (i < 5) ? bp_addr[i] : 32'h100;
         req_valid_i = 1'b1;
         @(negedge clk);
         chk($sformatf("bp_req_ready_%0d", i), 32'(req_ready_o), (i < 5) ? 32'd1 : 32'd0);
         if (i < 5) begin
            @(posedge clk); #1;
            e_new.rdata = bp_exp[i]; e_new.err = 1'b0;
            e_new.at_cyc = 0; e_new.chk_lat = 1'b0;
            sb.push_back(e_new);
         end
      end
      req_valid_i = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("bp_rsp_valid_held", 32'(rsp_valid_o), 32'd1);
      chk("bp_rsp_rdata_held", rsp_rdata_o, 32'hF0);
      chk("bp_still_full", 32'(req_ready_o), 32'd0);
      rsp_ready_i = 1'b1;
      k = 0;
      while (rsp_total < r0 + 5 && k < 80) begin
         @(posedge clk);
         k++;
      end
      chk("bp_rsp_count", 32'(rsp_total - r0), 32'd5);
      @(posedge clk); #1;
      chk("bp_ready_after", 32'(req_ready_o), 32'd1);
      chk("bp_sb_empty", 32'(sb.size()), 32'd0);

      // Reset while the FSM sits in RD_WAIT, with a second request queued.
      r0 = rsp_total;
      req_we_i = 1'b0; req_size_i = 2'd2; req_unsigned_i = 1'b0;
      req_addr_i = 32'h200; req_valid_i = 1'b1;
      @(posedge clk); #1;
      req_size_i = 2'd0; req_addr_i = 32'h100;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      @(posedge clk); #1;
      chk("rd_wait_mem_re", 32'(mem_re_o), 32'd3);
      chk("rd_wait_cs_n", 32'(mem_cs_no), 32'd1);
      chk("rd_wait_raddr", mem_read_address_o, 32'h200);
      rst_ni = 1'b0;
      #1;
      sb.delete();
      chk("midrst_cs_n", 32'(mem_cs_no), 32'd1);
      chk("midrst_mem_re", 32'(mem_re_o), 32'd0);
      chk("midrst_raddr", mem_read_address_o, 32'h0);
      chk("midrst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      @(negedge clk) rst_ni = 1'b1;
      #1;
      chk("postrst_req_ready", 32'(req_ready_o), 32'd1);
      cs0 = cs_total;
      repeat (8) @(posedge clk);
      #1;
      chk("postrst_no_cs", 32'(cs_total - cs0), 32'd0);
      chk("postrst_no_rsp", 32'(rsp_total - r0), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/spmem_lsu_ctrl.md
# spmem_lsu_ctrl

Load/store front-end for the sparse memory. It accepts byte/half/word load and store requests over a valid/ready handshake and buffers them in a small request FIFO. It issues each request onto the sparse memory port (chip select, read/write op type, addresses, write data), then returns extended load data or a store acknowledgement over a valid/ready response channel. The sparse-memory monitor observes the memory-side outputs of this block unchanged.

## Interface
- `ADDR_W`, 32, byte address width.
- `FIFO_DEPTH`, 4, request FIFO entries; must be a power of 2 and at least 2.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  asynchronous reset, active low.
- `req_valid_i` / `req_ready_o`  in / out  1 / 1  request handshake; transfer when both are high at a rising edge.
- `req_we_i`  in  1  1 = store, 0 = load.
- `req_size_i`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned_i`  in  1  loads only: zero-extend when 1.
- `req_addr_i`  in  ADDR_W  byte address.
- `req_wdata_i`  in  32  store data, right-aligned.
- `rsp_valid_o` / `rsp_ready_i`  out / in  1 / 1  response handshake.
- `rsp_rdata_o`  out  32  extended load data; 0 for stores and errors.
- `rsp_err_o`  out  1  misaligned access or illegal size.
- `mem_cs_no`  out  1  read chip select, active low.
- `mem_re_o`  out  3  read op type: 0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU.
- `mem_read_address_o`  out  ADDR_W  word-aligned read address (addr & ~3).
- `mem_read_data_i`  in  32  raw word from memory.
- `mem_we_o`  out  2  write op type: 0 NONE, 1 SB, 2 SH, 3 SW.
- `mem_write_address_o`  out  ADDR_W  byte write address.
- `mem_write_data_o`  out  32  write data, masked to the access size.

## Operation
- **Request FIFO**
  - `req_ready_o` = !full.
  - A push and a pop may occur in the same edge.
  - No bypass: a request always spends at least one cycle in the FIFO.
- **State machine**
  - States: IDLE, WRITE, RD_ISSUE, RD_WAIT, RESP.
  - IDLE with FIFO non-empty: pop the head and decode it.
    - Illegal request (size 11, half with addr[0]≠0, or word with addr[1:0]≠0) → RESP with err=1. No memory access.
    - Store → WRITE.
    - Load → RD_ISSUE.
  - WRITE (1 cycle): `mem_we_o`=type, `mem_write_address_o`=addr, `mem_write_data_o`=wdata masked to 8/16/32 bits. Next state is RESP.
  - RD_ISSUE (1 cycle): `mem_cs_no`=0, `mem_re_o`=type, `mem_read_address_o`=addr & ~3. Next state is RD_WAIT.
  - RD_WAIT (1 cycle): `mem_cs_no`=1; `mem_re_o` and the address are held. At the closing edge, register `mem_read_data_i`. Next state is RESP.
  - RESP: `rsp_valid_o`=1, outputs held stable until `rsp_ready_i`. On handshake, return to IDLE.
- **Load extraction**
  - Byte lane = addr[1:0] × 8; half lane = addr[1] × 16.
  - Sign-extend from bit 7 or 15 unless `req_unsigned_i`.
  - Word loads pass the data through unchanged.
- **Idle values**
  - `mem_re_o`=NONE, except in RD_ISSUE/RD_WAIT.
  - `mem_we_o`=NONE, `mem_write_*`=0, except in WRITE.
  - `mem_read_address_o`=0, except in RD_ISSUE/RD_WAIT.

## Timing
- **Reset values**: `req_ready_o`=1, `rsp_valid_o`=0, `rsp_rdata_o`=0, `rsp_err_o`=0, `mem_cs_no`=1, `mem_re_o`=0, `mem_we_o`=0, all addresses and data 0. FIFO is empty; state is IDLE.
- **Latency** (push at edge N, FIFO empty, IDLE):
  - Pop at edge N+1.
  - Load: cs low in cycle N+1..N+2; data captured at N+3; `rsp_valid_o` high from N+3.
  - Store: write strobe in cycle N+1..N+2; `rsp_valid_o` from N+2.
  - Error: `rsp_valid_o` from N+1.
- **Throughput**: one outstanding memory access at a time. Back-to-back loads produce one cs pulse per 4 cycles when `rsp_ready_i` is held high.
- **Output quality**: all memory-side outputs are registered and glitch-free. `mem_cs_no` rises exactly once per load.
- **Reset mid-operation**: immediately returns all outputs to their reset values, flushes the FIFO, and drops any pending response.
- **Response back-pressure**: `rsp_ready_i` low stalls in RESP. The FIFO keeps accepting requests until full; the FSM holds one request plus `FIFO_DEPTH` in the FIFO.

## Test plan
- **LB sign-extend**: memory word 0x807060F0 at 0x100; LB 0x100 → `rsp_rdata_o`=0xFFFFFFF0, err=0, `mem_re_o`=LB, `mem_read_address_o`=0x100, one `mem_cs_no` low pulse.
- **LBU/LH lanes**: same word. LBU 0x103 → 0x00000080; LH 0x102 → 0xFFFF8070; LHU 0x100 → 0x000060F0.
- **Store/load round trip**: SW 0x200 ← 0xDEADBEEF (`mem_we_o`=SW for exactly one cycle, data 0xDEADBEEF), then LW 0x200 → 0xDEADBEEF. SB 0x204 ← 0x123456AB → `mem_write_data_o`=0x000000AB.
- **Misaligned**: LW 0x102 and SH 0x301 → `rsp_err_o`=1, `rsp_rdata_o`=0, `mem_cs_no` stays 1, `mem_we_o` stays NONE.
- **Back-pressure/full**: `rsp_ready_i`=0, issue 6 loads back-to-back. One request is held in RESP and 4 fill the FIFO; `req_ready_o` goes low before the 6th is accepted. Release → 5 responses in order, then `req_ready_o`=1.
- **Reset mid-read**: assert `rst_ni` low during RD_WAIT → `mem_cs_no`=1, `mem_re_o`=0, `rsp_valid_o`=0 immediately. After release: FIFO empty, `req_ready_o`=1.
